cdb_arbiter: RTL and testbench

Completion/broadcast stage directly upstream of `reservation_station`. Collects result-tag completions from up to NUM_FU functional units, buffers them in small per-FU queues, and grants one completion per cycle onto the common data bus. It drives the CDB wake-up inputs `cdb_ready`/`cdb_tag` and the per-FU `free` vector consumed by the reservation station.

---
 rtl/cdb_arbiter_if.sv | 24 ++
 rtl/cdb_arbiter.sv | 97 +++++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: tag type and completion/CDB bundle shared by the FUs, the cdb_arbiter and the reservation station.
//   master: drives fu_done/fu_tag/squash; observes fu_stall/cdb_ready/cdb_tag/free/overflow
//   slave : the arbiter side of the same bundle
package cdb_arbiter_pkg;
  localparam int REG_W = 6;
  typedef struct packed {
    logic             ready;
    logic [REG_W-1:0] reg_num;
  } reg_t;
endpackage

interface cdb_arbiter_if #(parameter int NUM_FU = 5);
  import cdb_arbiter_pkg::*;
  logic [NUM_FU-1:0] fu_done;
  reg_t [NUM_FU-1:0] fu_tag;
  logic              squash;
  logic [NUM_FU-1:0] fu_stall;
  logic              cdb_ready;
  reg_t              cdb_tag;
  logic [NUM_FU-1:0] free;
  logic              overflow;
  modport master (output fu_done, fu_tag, squash, input fu_stall, cdb_ready, cdb_tag, free, overflow);
  modport slave (input fu_done, fu_tag, squash, output fu_stall, cdb_ready, cdb_tag, free, overflow);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU completion queues with round-robin grant of one tag per cycle onto the CDB.
//   i_clock : rising-edge clock
//   i_reset : asynchronous active-low reset
//   io_cdb  : completion inputs (fu_done/fu_tag/squash) and CDB outputs (fu_stall/cdb_ready/cdb_tag/free/overflow)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 5,
  parameter int DEPTH  = 2
) (
  input logic          i_clock,
  input logic          i_reset,
  cdb_arbiter_if.slave io_cdb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
  logic [REG_W-1:0]  r_mem [NUM_FU][DEPTH];
  logic [CW-1:0]     r_cnt [NUM_FU];
  logic [PW-1:0]     r_wp  [NUM_FU];
  logic [PW-1:0]     r_rp  [NUM_FU];
  logic [RW-1:0]     r_rr;
  logic              r_cdb_ready;
  reg_t              r_cdb_tag;
  logic [NUM_FU-1:0] r_free;
  logic              r_overflow;
  logic [NUM_FU-1:0] w_ne, w_full, w_push, w_pop, w_drop;
  logic              w_found, w_win;
  logic [RW-1:0]     w_gnt, w_nxt;
  logic [REG_W-1:0]  w_head;
  for (genvar i = 0; i < NUM_FU; i++) begin : g_q
    assign w_ne[i]   = r_cnt[i] != '0;
    assign w_full[i] = r_cnt[i] == CW'(DEPTH);
    assign w_push[i] = io_cdb.fu_done[i] && !w_full[i];
    assign w_drop[i] = io_cdb.fu_done[i] && w_full[i];
    assign w_pop[i]  = w_found && w_gnt == RW'(i);
  end
  // Scan from rr upward, wrapping at NUM_FU; the first non-empty queue wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      int j;
      j = int'(r_rr) + k;
      j = j >= NUM_FU ? j - NUM_FU : j;
      if (!w_found && w_ne[RW'(j)]) begin
        w_found = 1'b1;
        w_gnt = RW'(j);
      end
    end
  end
  assign w_win  = w_found && !io_cdb.squash;
  assign w_nxt  = w_gnt == RW'(NUM_FU - 1) ? '0 : w_gnt + RW'(1);
  assign w_head = r_mem[w_gnt][r_rp[w_gnt]];
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset)
      for (int i = 0; i < NUM_FU; i++) begin
        r_cnt[i] <= '0;
        r_wp[i] <= '0;
        r_rp[i] <= '0;
      end
    else if (io_cdb.squash)
      for (int i = 0; i < NUM_FU; i++) begin
        r_cnt[i] <= '0;
        r_wp[i] <= '0;
        r_rp[i] <= '0;
      end
    else
      for (int i = 0; i < NUM_FU; i++) begin
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
        r_wp[i] <= r_wp[i] + PW'(w_push[i]);
        r_rp[i] <= r_rp[i] + PW'(w_pop[i]);
      end
  // Storage needs no reset: counts alone decide which entries are live.
  always_ff @(posedge i_clock)
    for (int i = 0; i < NUM_FU; i++)
      if (w_push[i] && !io_cdb.squash) r_mem[i][r_wp[i]] <= io_cdb.fu_tag[i].reg_num;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      r_rr <= '0;
      r_cdb_ready <= 1'b0;
      r_cdb_tag <= '0;
      r_free <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (!io_cdb.squash && |w_drop);
      r_cdb_ready <= w_win;
      r_cdb_tag <= w_win ? reg_t'({1'b1, w_head}) : '0;
      r_free <= w_win ? NUM_FU'(1) << w_gnt : '0;
      r_rr <= io_cdb.squash ? '0 : w_found ? w_nxt : r_rr;
    end
  assign io_cdb.fu_stall  = w_full;
  assign io_cdb.cdb_ready = r_cdb_ready;
  assign io_cdb.cdb_tag   = r_cdb_tag;
  assign io_cdb.free      = r_free;
  assign io_cdb.overflow  = r_overflow;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus checked against a queue-based reference model of cdb_arbiter.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  localparam int N = 5;
  localparam int D = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int q [N][$];
  int m_rr = 0;
  int m_num = 0;
  int m_free = 0;
  bit m_rdy = 0;
  bit m_ovf = 0;
  cdb_arbiter_if #(.NUM_FU(N)) bus ();
  cdb_arbiter #(.NUM_FU(N), .DEPTH(D)) dut (.i_clock(clk), .i_reset(rst_n), .io_cdb(bus));
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic void m_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    m_rr = 0;
    m_rdy = 0;
    m_num = 0;
    m_free = 0;
    m_ovf = 0;
  endfunction
  function automatic void m_step();
    int g;
    bit full [N];
    g = -1;
    if (bus.squash) begin
      for (int i = 0; i < N; i++) q[i].delete();
      m_rr = 0;
      m_rdy = 0;
      m_num = 0;
      m_free = 0;
      return;
    end
    for (int i = 0; i < N; i++) full[i] = q[i].size() == D;
    for (int k = 0; k < N; k++)
      if (g < 0 && q[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
    if (g >= 0) begin
      m_num = q[g].pop_front();
      m_rdy = 1;
      m_free = 1 << g;
      m_rr = (g + 1) % N;
    end else begin
      m_rdy = 0;
      m_num = 0;
      m_free = 0;
    end
    for (int i = 0; i < N; i++)
      if (bus.fu_done[i]) begin
        if (full[i]) m_ovf = 1;
        else q[i].push_back(int'(bus.fu_tag[i].reg_num));
      end
  endfunction
  function automatic void compare();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) if (q[i].size() == D) s |= 1 << i;
    chk("cdb_ready", int'(bus.cdb_ready), int'(m_rdy));
    chk("cdb_tag", int'(bus.cdb_tag), m_rdy ? 64 + m_num : 0);
    chk("free", int'(bus.free), m_free);
    chk("fu_stall", int'(bus.fu_stall), s);
    chk("overflow", int'(bus.overflow), int'(m_ovf));
  endfunction
  always @(negedge rst_n) m_reset();
  always @(posedge clk) begin
    if (rst_n) m_step();
    #1;
    compare();
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic set_tag(input int i, input int t);
    bus.fu_tag[i] = reg_t'({1'b0, REG_W'(t)});
  endtask
  task automatic idle();
    bus.fu_done = '0;
    bus.squash = 1'b0;
  endtask
  initial begin
    int prev;
    bus.fu_done = '0;
    bus.fu_tag = '0;
    bus.squash = 1'b0;
    repeat (3) tick();
    chk("rst_cdb_ready", int'(bus.cdb_ready), 0);
    chk("rst_free", int'(bus.free), 0);
    chk("rst_stall", int'(bus.fu_stall), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    rst_n = 1'b1;
    bus.fu_done = 5'b00100;
    set_tag(2, 7);
    tick();
    idle();
    tick();
    chk("single_ready", int'(bus.cdb_ready), 1);
    chk("single_tag", int'(bus.cdb_tag), 71);
    chk("single_free", int'(bus.free), 4);
    tick();
    chk("single_ready_off", int'(bus.cdb_ready), 0);
    chk("single_tag_off", int'(bus.cdb_tag), 0);
    chk("single_free_off", int'(bus.free), 0);
    bus.squash = 1'b1;
    tick();
    idle();
    bus.fu_done = 5'b10011;
    set_tag(0, 5);
    set_tag(1, 6);
    set_tag(4, 8);
    tick();
    idle();
    tick();
    chk("simul_tag0", int'(bus.cdb_tag), 69);
    chk("simul_free0", int'(bus.free), 1);
    tick();
    chk("simul_tag1", int'(bus.cdb_tag), 70);
    chk("simul_free1", int'(bus.free), 2);
    tick();
    chk("simul_tag2", int'(bus.cdb_tag), 72);
    chk("simul_free2", int'(bus.free), 16);
    tick();
    chk("simul_idle", int'(bus.cdb_ready), 0);
    prev = 0;
    set_tag(0, 1);
    set_tag(3, 3);
    for (int c = 0; c < 16; c++) begin
      bus.fu_done = {1'b0, !bus.fu_stall[3], 2'b00, !bus.fu_stall[0]};
      tick();
      if (bus.free != '0 && prev != 0) chk("rr_alternate", int'(int'(bus.free) != prev), 1);
      prev = int'(bus.free);
    end
    idle();
    repeat (6) tick();
    bus.squash = 1'b1;
    tick();
    idle();
    for (int c = 0; c < 6; c++) begin
      bus.fu_done = 5'b00111;
      for (int i = 0; i < 3; i++) set_tag(i, 16 + c * 3 + i);
      tick();
      if (c == 2) begin
        chk("ovf_stall2", int'(bus.fu_stall[2]), 1);
        chk("ovf_set", int'(bus.overflow), 1);
      end
    end
    idle();
    repeat (8) tick();
    chk("ovf_sticky", int'(bus.overflow), 1);
    for (int c = 0; c < 3; c++) begin
      bus.fu_done = 5'b11111;
      for (int i = 0; i < N; i++) set_tag(i, 40 + c * 5 + i);
      tick();
    end
    bus.fu_done = 5'b01000;
    set_tag(3, 63);
    bus.squash = 1'b1;
    tick();
    idle();
    chk("squash_ready", int'(bus.cdb_ready), 0);
    chk("squash_free", int'(bus.free), 0);
    chk("squash_stall", int'(bus.fu_stall), 0);
    chk("squash_ovf_kept", int'(bus.overflow), 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("squash_quiet", int'(bus.cdb_ready), 0);
    end
    for (int c = 0; c < 2; c++) begin
      bus.fu_done = 5'b00111;
      for (int i = 0; i < 3; i++) set_tag(i, 30 + c * 3 + i);
      tick();
    end
    idle();
    tick();
    chk("pre_rst_ready", int'(bus.cdb_ready), 1);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ready", int'(bus.cdb_ready), 0);
    chk("mid_rst_tag", int'(bus.cdb_tag), 0);
    chk("mid_rst_free", int'(bus.free), 0);
    chk("mid_rst_stall", int'(bus.fu_stall), 0);
    chk("mid_rst_ovf", int'(bus.overflow), 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_quiet", int'(bus.cdb_ready), 0);
    end
    for (int c = 0; c < 3000; c++) begin
      bit ign;
      ign = $urandom_range(0, 19) == 0;
      bus.squash = $urandom_range(0, 39) == 0;
      for (int i = 0; i < N; i++) begin
        bus.fu_done[i] = $urandom_range(0, 99) < 45 && (ign || !bus.fu_stall[i]);
        bus.fu_tag[i] = reg_t'(7'($urandom));
      end
      tick();
    end
    idle();
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
